// File: rtl/sram_arb_pkg.sv
// rtl/sram_arb_pkg.sv - shared state encoding, port ids and limits for the SRAM arbiter/controller
package sram_arb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_RD        = 3'd1,
    ST_RD_DONE   = 3'd2,
    ST_WR_SETUP  = 3'd3,
    ST_WR_STROBE = 3'd4,
    ST_WR_HOLD   = 3'd5
  } state_e;

  localparam logic PORT_CPU   = 1'b0;
  localparam logic PORT_DMA   = 1'b1;

  localparam int   ADDR_W_DEF = 19;
  localparam int   WAIT_MAX   = 15;

  // Strobe counter preload: the counter runs down to zero, so a phase of N cycles loads N-1.
  function automatic logic [3:0] strobe_load(input int wait_cycles);
    return 4'(wait_cycles - 1);
  endfunction

endpackage

// File: rtl/sram_arb_ctrl_if.sv
// rtl/sram_arb_ctrl_if.sv - requester handshakes and SRAM pin bundle for sram_arb_ctrl
interface sram_arb_ctrl_if
  import sram_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
);
  logic              req0;
  logic              req1;
  logic              we0;
  logic              we1;
  logic [ADDR_W-1:0] addr0;
  logic [ADDR_W-1:0] addr1;
  logic [7:0]        wdata0;
  logic [7:0]        wdata1;
  logic              ack0;
  logic              ack1;
  logic [7:0]        rdata;
  logic [ADDR_W-1:0] sram_addr;
  logic              sram_cen;
  logic              sram_wen;
  logic              sram_oen;
  logic              sram_oe;
  logic [7:0]        sram_dout;
  logic [7:0]        sram_din;

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, sram_din,
    output ack0, ack1, rdata, sram_addr, sram_cen, sram_wen, sram_oen, sram_oe, sram_dout
  );

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, sram_din,
    input  ack0, ack1, rdata, sram_addr, sram_cen, sram_wen, sram_oen, sram_oe, sram_dout
  );
endinterface

// File: rtl/sram_arb_sel.sv
// rtl/sram_arb_sel.sv - two-way grant selector; fixed priority, or round-robin when SRAM_ARB_RR_EN is defined
module sram_arb_sel
  import sram_arb_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic req0,
  input  logic req1,
  input  logic take,
  output logic gnt_valid,
  output logic gnt_port
);

`ifdef SRAM_ARB_RR_EN
  logic last_q;
  logic last_d;

  // On a tie the port that was not granted last wins; single requests win outright.
  always_comb begin
    gnt_valid = req0 | req1;
    if (req0 && req1) begin
      gnt_port = ~last_q;
    end else if (req1) begin
      gnt_port = PORT_DMA;
    end else begin
      gnt_port = PORT_CPU;
    end
    last_d = take ? gnt_port : last_q;
  end

  // Last-grant flag starts at the DMA port so the CPU wins the first tie.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_q <= PORT_DMA;
    end else begin
      last_q <= last_d;
    end
  end
`else
  logic unused_sel;

  // CPU port always wins; the DMA port is served only when the CPU is not asking.
  always_comb begin
    gnt_valid = req0 | req1;
    gnt_port  = req0 ? PORT_CPU : PORT_DMA;
  end

  assign unused_sel = clk ^ reset ^ take;
`endif

endmodule

// File: rtl/sram_arb_ctrl.sv
// rtl/sram_arb_ctrl.sv - timed async SRAM read/write sequencer shared by two requesters (SRAM_ARB_RR_EN: round-robin)
module sram_arb_ctrl
  import sram_arb_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int WAIT_CYCLES = 1            // strobe length, 1..WAIT_MAX
) (
  input logic            clk,
  input logic            reset,
  sram_arb_ctrl_if.slave bus
);

  state_e            state_q, state_d;
  logic              port_q, port_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        dout_q, dout_d;
  logic [7:0]        rdata_q, rdata_d;
  logic              cen_q, cen_d;
  logic              wen_q, wen_d;
  logic              oen_q, oen_d;
  logic              oe_q, oe_d;
  logic              ack0_q, ack0_d;
  logic              ack1_q, ack1_d;

  logic              take;
  logic              gnt_valid;
  logic              gnt_port;
  logic              gnt_we;
  logic [ADDR_W-1:0] gnt_addr;
  logic [7:0]        gnt_wdata;

  sram_arb_sel u_sel (
    .clk       (clk),
    .reset     (reset),
    .req0      (bus.req0),
    .req1      (bus.req1),
    .take      (take),
    .gnt_valid (gnt_valid),
    .gnt_port  (gnt_port)
  );

  assign gnt_we    = (gnt_port == PORT_DMA) ? bus.we1    : bus.we0;
  assign gnt_addr  = (gnt_port == PORT_DMA) ? bus.addr1  : bus.addr0;
  assign gnt_wdata = (gnt_port == PORT_DMA) ? bus.wdata1 : bus.wdata0;

  // Next-state and next-output logic; every pin is a flop so strobe edges are glitch-free.
  always_comb begin
    state_d = state_q;
    port_d  = port_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    dout_d  = dout_q;
    rdata_d = rdata_q;
    cen_d   = cen_q;
    wen_d   = wen_q;
    oen_d   = oen_q;
    oe_d    = oe_q;
    ack0_d  = 1'b0;
    ack1_d  = 1'b0;
    take    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        cen_d = 1'b1;
        wen_d = 1'b1;
        oen_d = 1'b1;
        oe_d  = 1'b0;
        if (gnt_valid) begin
          take   = 1'b1;
          port_d = gnt_port;
          addr_d = gnt_addr;
          cnt_d  = strobe_load(WAIT_CYCLES);
          cen_d  = 1'b0;
          if (gnt_we) begin
            // Drive the data pins a full cycle before WEn falls.
            dout_d  = gnt_wdata;
            oe_d    = 1'b1;
            state_d = ST_WR_SETUP;
          end else begin
            oen_d   = 1'b0;
            state_d = ST_RD;
          end
        end
      end

      ST_RD: begin
        if (cnt_q == 4'd0) begin
          rdata_d = bus.sram_din;
          cen_d   = 1'b1;
          oen_d   = 1'b1;
          ack0_d  = (port_q == PORT_CPU);
          ack1_d  = (port_q == PORT_DMA);
          state_d = ST_RD_DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      ST_RD_DONE: begin
        state_d = ST_IDLE;
      end

      ST_WR_SETUP: begin
        wen_d   = 1'b0;
        state_d = ST_WR_STROBE;
      end

      ST_WR_STROBE: begin
        if (cnt_q == 4'd0) begin
          // WEn rises while address and data stay put, giving the SRAM its hold time.
          wen_d   = 1'b1;
          ack0_d  = (port_q == PORT_CPU);
          ack1_d  = (port_q == PORT_DMA);
          state_d = ST_WR_HOLD;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      ST_WR_HOLD: begin
        cen_d   = 1'b1;
        oe_d    = 1'b0;
        state_d = ST_IDLE;
      end

      default: begin
        cen_d   = 1'b1;
        wen_d   = 1'b1;
        oen_d   = 1'b1;
        oe_d    = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset parks the bus with all strobes high and pins undriven.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      port_q  <= PORT_CPU;
      cnt_q   <= 4'd0;
      addr_q  <= '0;
      dout_q  <= 8'h00;
      rdata_q <= 8'h00;
      cen_q   <= 1'b1;
      wen_q   <= 1'b1;
      oen_q   <= 1'b1;
      oe_q    <= 1'b0;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      port_q  <= port_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      dout_q  <= dout_d;
      rdata_q <= rdata_d;
      cen_q   <= cen_d;
      wen_q   <= wen_d;
      oen_q   <= oen_d;
      oe_q    <= oe_d;
      ack0_q  <= ack0_d;
      ack1_q  <= ack1_d;
    end
  end

  assign bus.ack0      = ack0_q;
  assign bus.ack1      = ack1_q;
  assign bus.rdata     = rdata_q;
  assign bus.sram_addr = addr_q;
  assign bus.sram_cen  = cen_q;
  assign bus.sram_wen  = wen_q;
  assign bus.sram_oen  = oen_q;
  assign bus.sram_oe   = oe_q;
  assign bus.sram_dout = dout_q;

endmodule

// File: tb/tb_sram_arb_ctrl.sv
// tb/tb_sram_arb_ctrl.sv - self-checking bench for sram_arb_ctrl (SRAM_ARB_RR_EN selects round-robin expectations)
module tb_sram_arb_ctrl;
  import sram_arb_pkg::*;

  localparam int AW  = 19;
  localparam int W_A = 1;
  localparam int W_B = 3;
`ifdef SRAM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int sel = 0;

  logic          req0 = 0, req1 = 0, we0 = 0, we1 = 0;
  logic [AW-1:0] addr0 = '0, addr1 = '0;
  logic [7:0]    wdata0 = 0, wdata1 = 0;
  logic [7:0]    mem_dout;
  logic          m_last = PORT_DMA;

  sram_arb_ctrl_if #(.ADDR_W(AW)) ifa ();
  sram_arb_ctrl_if #(.ADDR_W(AW)) ifb ();

  assign ifa.req0 = req0 && (sel == 0);
  assign ifa.req1 = req1 && (sel == 0);
  assign ifb.req0 = req0 && (sel == 1);
  assign ifb.req1 = req1 && (sel == 1);
  assign ifa.we0 = we0;       assign ifb.we0 = we0;
  assign ifa.we1 = we1;       assign ifb.we1 = we1;
  assign ifa.addr0 = addr0;   assign ifb.addr0 = addr0;
  assign ifa.addr1 = addr1;   assign ifb.addr1 = addr1;
  assign ifa.wdata0 = wdata0; assign ifb.wdata0 = wdata0;
  assign ifa.wdata1 = wdata1; assign ifb.wdata1 = wdata1;
  assign ifa.sram_din = mem_dout;
  assign ifb.sram_din = mem_dout;

  sram_arb_ctrl #(.ADDR_W(AW), .WAIT_CYCLES(W_A)) dut_a (.clk(clk), .reset(reset), .bus(ifa));
  sram_arb_ctrl #(.ADDR_W(AW), .WAIT_CYCLES(W_B)) dut_b (.clk(clk), .reset(reset), .bus(ifb));

  logic          m_ack0, m_ack1, m_cen, m_wen, m_oen, m_oe;
  logic [7:0]    m_rdata, m_dout;
  logic [AW-1:0] m_addr;

  always_comb begin
    if (sel == 1) begin
      m_ack0 = ifb.ack0; m_ack1 = ifb.ack1; m_cen = ifb.sram_cen; m_wen = ifb.sram_wen;
      m_oen = ifb.sram_oen; m_oe = ifb.sram_oe; m_rdata = ifb.rdata; m_dout = ifb.sram_dout;
      m_addr = ifb.sram_addr;
    end else begin
      m_ack0 = ifa.ack0; m_ack1 = ifa.ack1; m_cen = ifa.sram_cen; m_wen = ifa.sram_wen;
      m_oen = ifa.sram_oen; m_oe = ifa.sram_oe; m_rdata = ifa.rdata; m_dout = ifa.sram_dout;
      m_addr = ifa.sram_addr;
    end
  end

  function automatic logic [7:0] init_val(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  // Async SRAM: reads while CEn and OEn are low, stores while CEn and WEn are low.
  logic [7:0] mem [0:65535];
  assign mem_dout = (!m_cen && !m_oen) ? mem[m_addr[15:0]] : 8'h00;
  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = init_val(16'(i));
    forever begin
      @(negedge clk);
      if (!m_cen && !m_wen) mem[m_addr[15:0]] = m_dout;
    end
  end

  // Reference contents as seen by the requesters: initial pattern plus completed writes.
  logic [7:0] shadow [logic [15:0]];
  function automatic logic [7:0] exp_mem(input logic [15:0] a);
    if (shadow.exists(a)) return shadow[a];
    return init_val(a);
  endfunction

  // Bus-safety invariants on both instances every cycle.
  logic [AW-1:0] pa_addr = '0, pb_addr = '0;
  always @(negedge clk) begin
    checks++;
    if ((ifa.sram_oe && !ifa.sram_oen) || (ifb.sram_oe && !ifb.sram_oen)) begin
      failures++;
      $display("FAIL inv_oe_oen: a oe=%b oen=%b b oe=%b oen=%b, required never oe=1 with oen=0",
               ifa.sram_oe, ifa.sram_oen, ifb.sram_oe, ifb.sram_oen);
    end
    checks++;
    if ((!ifa.sram_wen && (!ifa.sram_oe || ifa.sram_addr !== pa_addr)) ||
        (!ifb.sram_wen && (!ifb.sram_oe || ifb.sram_addr !== pb_addr))) begin
      failures++;
      $display("FAIL inv_wen_addr: a addr=%h prev=%h oe=%b b addr=%h prev=%h oe=%b, required stable addr and oe=1 while wen=0",
               ifa.sram_addr, pa_addr, ifa.sram_oe, ifb.sram_addr, pb_addr, ifb.sram_oe);
    end
    pa_addr = ifa.sram_addr;
    pb_addr = ifb.sram_addr;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic p, input logic we, input logic [15:0] a, input logic [7:0] d);
    if (p == PORT_CPU) begin
      req0 = 1'b1; we0 = we; addr0 = AW'(a); wdata0 = d;
    end else begin
      req1 = 1'b1; we1 = we; addr1 = AW'(a); wdata1 = d;
    end
  endtask

  task automatic drop_req(input logic p);
    if (p == PORT_CPU) req0 = 1'b0;
    else req1 = 1'b0;
  endtask

  // Counts cycles from the IDLE cycle that sees the request up to the ack cycle.
  task automatic wait_ack(output int lat, output logic [1:0] ackv, output logic [7:0] rd,
                          output int wen_lo, output int oen_lo);
    bit got;
    got = 0; lat = 0; wen_lo = 0; oen_lo = 0; ackv = 2'b00; rd = 8'h00;
    for (int c = 0; c < 60 && !got; c++) begin
      @(negedge clk);
      if (!m_wen) wen_lo++;
      if (!m_oen) oen_lo++;
      if (m_ack0 || m_ack1) begin
        got = 1; ackv = {m_ack1, m_ack0}; rd = m_rdata;
      end else begin
        lat++;
      end
    end
    checks++;
    if (!got) begin
      failures++;
      $display("FAIL ack_timeout: no ack within %0d cycles, required an ack", lat);
    end
  endtask

  task automatic run_txn(input logic p, input logic we, input logic [15:0] a, input logic [7:0] d,
                         output int lat, output logic [1:0] ackv, output logic [7:0] rd,
                         output int wen_lo, output int oen_lo);
    set_req(p, we, a, d);
    wait_ack(lat, ackv, rd, wen_lo, oen_lo);
    if (we) shadow[a] = d;
    if (sel == 0) m_last = p;
    step();
    drop_req(p);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) step();
    @(negedge clk);
    checks++;
    if ({ifa.sram_cen, ifa.sram_wen, ifa.sram_oen, ifa.sram_oe, ifa.ack0, ifa.ack1} !== 6'b111000 ||
        {ifb.sram_cen, ifb.sram_wen, ifb.sram_oen, ifb.sram_oe, ifb.ack0, ifb.ack1} !== 6'b111000) begin
      failures++;
      $display("FAIL reset_strobes: a=%b b=%b (cen,wen,oen,oe,ack0,ack1), required 111000",
               {ifa.sram_cen, ifa.sram_wen, ifa.sram_oen, ifa.sram_oe, ifa.ack0, ifa.ack1},
               {ifb.sram_cen, ifb.sram_wen, ifb.sram_oen, ifb.sram_oe, ifb.ack0, ifb.ack1});
    end
    checks++;
    if (ifa.sram_addr !== '0 || ifb.sram_addr !== '0 || ifa.sram_dout !== 8'h00 || ifb.sram_dout !== 8'h00 ||
        ifa.rdata !== 8'h00 || ifb.rdata !== 8'h00) begin
      failures++;
      $display("FAIL reset_data: addr a=%h b=%h dout a=%h b=%h rdata a=%h b=%h, required all zero",
               ifa.sram_addr, ifb.sram_addr, ifa.sram_dout, ifb.sram_dout, ifa.rdata, ifb.rdata);
    end
    step();
    reset = 1'b0;
    m_last = PORT_DMA;
  endtask

  task automatic test_reset_mid_write();
    int lat, wl, ol;
    logic [1:0] ackv;
    logic [7:0] rd;
    sel = 0;
    set_req(PORT_CPU, 1'b1, 16'h7777, 8'h3C);
    step();
    step();
    reset = 1'b1;
    req0 = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      @(negedge clk);
      checks++;
      if ({ifa.sram_cen, ifa.sram_wen, ifa.sram_oen, ifa.sram_oe, ifa.ack0, ifa.ack1} !== 6'b111000) begin
        failures++;
        $display("FAIL reset_mid_write[%0d]: got %b (cen,wen,oen,oe,ack0,ack1), required 111000", k,
                 {ifa.sram_cen, ifa.sram_wen, ifa.sram_oen, ifa.sram_oe, ifa.ack0, ifa.ack1});
      end
    end
    reset = 1'b0;
    m_last = PORT_DMA;
    step();
    run_txn(PORT_CPU, 1'b0, 16'h0010, 8'h00, lat, ackv, rd, wl, ol);
    checks++;
    if (lat !== 2 || ackv !== 2'b01 || rd !== exp_mem(16'h0010)) begin
      failures++;
      $display("FAIL post_reset_read: lat=%0d ack=%b rdata=%h, required lat=2 ack=01 rdata=%h",
               lat, ackv, rd, exp_mem(16'h0010));
    end
  endtask

  task automatic test_write_read();
    int lat, wl, ol;
    logic [1:0] ackv;
    logic [7:0] rd;
    sel = 0;
    run_txn(PORT_CPU, 1'b1, 16'h1234, 8'hA5, lat, ackv, rd, wl, ol);
    checks++;
    if (lat !== W_A + 2 || ackv !== 2'b01 || wl !== W_A || ol !== 0) begin
      failures++;
      $display("FAIL write_1234: lat=%0d ack=%b wen_lo=%0d oen_lo=%0d, required lat=%0d ack=01 wen_lo=%0d oen_lo=0",
               lat, ackv, wl, ol, W_A + 2, W_A);
    end
    run_txn(PORT_CPU, 1'b0, 16'h1234, 8'h00, lat, ackv, rd, wl, ol);
    checks++;
    if (lat !== W_A + 1 || ackv !== 2'b01 || rd !== 8'hA5 || wl !== 0) begin
      failures++;
      $display("FAIL read_1234: lat=%0d ack=%b rdata=%h wen_lo=%0d, required lat=%0d ack=01 rdata=a5 wen_lo=0",
               lat, ackv, rd, wl, W_A + 1);
    end
  endtask

  task automatic test_wait3();
    int lat, wl, ol;
    logic [1:0] ackv;
    logic [7:0] rd, d;
    sel = 1;
    step();
    run_txn(PORT_CPU, 1'b0, 16'h0005, 8'h00, lat, ackv, rd, wl, ol);
    checks++;
    if (lat !== W_B + 1 || ackv !== 2'b01 || ol !== W_B || rd !== exp_mem(16'h0005)) begin
      failures++;
      $display("FAIL wait3_read: lat=%0d ack=%b oen_lo=%0d rdata=%h, required lat=%0d ack=01 oen_lo=%0d rdata=%h",
               lat, ackv, ol, rd, W_B + 1, W_B, exp_mem(16'h0005));
    end
    d = 8'($urandom);
    run_txn(PORT_DMA, 1'b1, 16'h0006, d, lat, ackv, rd, wl, ol);
    checks++;
    if (lat !== W_B + 2 || ackv !== 2'b10 || wl !== W_B) begin
      failures++;
      $display("FAIL wait3_write: lat=%0d ack=%b wen_lo=%0d, required lat=%0d ack=10 wen_lo=%0d",
               lat, ackv, wl, W_B + 2, W_B);
    end
    run_txn(PORT_DMA, 1'b0, 16'h0006, 8'h00, lat, ackv, rd, wl, ol);
    checks++;
    if (lat !== W_B + 1 || rd !== d) begin
      failures++;
      $display("FAIL wait3_readback: lat=%0d rdata=%h, required lat=%0d rdata=%h", lat, rd, W_B + 1, d);
    end
    sel = 0;
    step();
  endtask

  task automatic test_random();
    int lat, wl, ol;
    logic [1:0] ackv;
    logic [7:0] rd, d, er;
    logic p, we;
    logic [15:0] a;
    sel = 0;
    for (int k = 0; k < 24; k++) begin
      p  = 1'($urandom_range(0, 1));
      we = 1'($urandom_range(0, 1));
      a  = 16'($urandom_range(0, 15));
      d  = 8'($urandom);
      er = exp_mem(a);
      run_txn(p, we, a, d, lat, ackv, rd, wl, ol);
      checks++;
      if (lat !== (we ? W_A + 2 : W_A + 1) || ackv !== (p ? 2'b10 : 2'b01) ||
          (!we && rd !== er) || wl !== (we ? W_A : 0) || ol !== (we ? 0 : W_A)) begin
        failures++;
        $display("FAIL random[%0d] p=%0d we=%0d a=%h: lat=%0d ack=%b rdata=%h wen_lo=%0d oen_lo=%0d, required lat=%0d ack=%b rdata=%h",
                 k, p, we, a, lat, ackv, rd, wl, ol, we ? W_A + 2 : W_A + 1, p ? 2'b10 : 2'b01, er);
      end
    end
  endtask

  task automatic test_simultaneous();
    int lat, wl, ol;
    logic [1:0] ackv;
    logic [7:0] rd;
    logic w;
    sel = 0;
    w = RR ? ~m_last : PORT_CPU;
    set_req(PORT_CPU, 1'b0, 16'h0100, 8'h00);
    set_req(PORT_DMA, 1'b0, 16'h0200, 8'h00);
    wait_ack(lat, ackv, rd, wl, ol);
    checks++;
    if (lat !== W_A + 1 || ackv !== (w ? 2'b10 : 2'b01) || rd !== exp_mem(w ? 16'h0200 : 16'h0100)) begin
      failures++;
      $display("FAIL simul_first: lat=%0d ack=%b rdata=%h, required lat=%0d ack=%b rdata=%h",
               lat, ackv, rd, W_A + 1, w ? 2'b10 : 2'b01, exp_mem(w ? 16'h0200 : 16'h0100));
    end
    m_last = w;
    step();
    drop_req(w);
    wait_ack(lat, ackv, rd, wl, ol);
    checks++;
    if (lat !== W_A + 1 || ackv !== (w ? 2'b01 : 2'b10) || rd !== exp_mem(w ? 16'h0100 : 16'h0200)) begin
      failures++;
      $display("FAIL simul_second: lat=%0d ack=%b rdata=%h, required lat=%0d ack=%b rdata=%h",
               lat, ackv, rd, W_A + 1, w ? 2'b01 : 2'b10, exp_mem(w ? 16'h0100 : 16'h0200));
    end
    m_last = ~w;
    step();
    drop_req(~w);
  endtask

  task automatic test_contend();
    int lat, wl, ol;
    logic [1:0] ackv;
    logic [7:0] rd, er;
    logic w;
    logic        pwe   [2];
    logic [15:0] paddr [2];
    logic [7:0]  pdata [2];
    sel = 0;
    for (int p = 0; p < 2; p++) begin
      pwe[p] = 1'($urandom_range(0, 1)); paddr[p] = 16'($urandom_range(0, 15)); pdata[p] = 8'($urandom);
      set_req(1'(p), pwe[p], paddr[p], pdata[p]);
    end
    for (int k = 0; k < 6; k++) begin
      w  = RR ? ~m_last : PORT_CPU;
      er = exp_mem(paddr[w]);
      wait_ack(lat, ackv, rd, wl, ol);
      checks++;
      if (ackv !== (w ? 2'b10 : 2'b01) || lat !== (pwe[w] ? W_A + 2 : W_A + 1) || (!pwe[w] && rd !== er)) begin
        failures++;
        $display("FAIL contend[%0d]: ack=%b lat=%0d rdata=%h, required ack=%b lat=%0d rdata=%h",
                 k, ackv, lat, rd, w ? 2'b10 : 2'b01, pwe[w] ? W_A + 2 : W_A + 1, er);
      end
      if (pwe[w]) shadow[paddr[w]] = pdata[w];
      m_last = w;
      step();
      pwe[w] = 1'($urandom_range(0, 1)); paddr[w] = 16'($urandom_range(0, 15)); pdata[w] = 8'($urandom);
      set_req(w, pwe[w], paddr[w], pdata[w]);
    end
    req0 = 1'b0;
    req1 = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_reset_mid_write();
    test_write_read();
    test_wait3();
    test_random();
    test_simultaneous();
    test_contend();
    repeat (3) step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
